// File: rtl/video_ts_task_sched_pkg.sv
// Shared types for the TS-line task scheduler:
// task bundle, FSM states and task cost helper.
package video_ts_pkg;
  localparam int TS_X_W    = 9;
  localparam int TS_SZ_W   = 3;
  localparam int TS_ADDR_W = 6;
  localparam int TS_LINE_W = 9;
  localparam int TS_PAGE_W = 8;
  localparam int TS_PAL_W  = 4;

  typedef struct packed {
    logic [TS_X_W-1:0]    x;
    logic [TS_SZ_W-1:0]   size;
    logic                 flip;
    logic [TS_ADDR_W-1:0] addr;
    logic [TS_LINE_W-1:0] line;
    logic [TS_PAGE_W-1:0] page;
    logic [TS_PAL_W-1:0]  pal;
  } ts_task_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_STOP = 2'd2,
    ST_DONE = 2'd3
  } ts_state_e;

  // DRAM words fetched by one task: two per render cycle.
  function automatic logic [TS_SZ_W+1:0] ts_cost(
    input logic [TS_SZ_W-1:0] size
  );
    return {({1'b0, size} + 4'd1), 1'b0};
  endfunction
endpackage

// File: rtl/video_ts_task_sched_if.sv
// Task push channel from the TS descriptor parser
// into the scheduler (valid/ready handshake).
interface video_ts_task_sched_if;
  logic       task_valid;
  logic       task_ready;
  logic [8:0] task_x;
  logic [2:0] task_size;
  logic       task_flip;
  logic [5:0] task_addr;
  logic [8:0] task_line;
  logic [7:0] task_page;
  logic [3:0] task_pal;

  modport master (
    output task_valid, task_x, task_size, task_flip,
    output task_addr, task_line, task_page, task_pal,
    input  task_ready
  );

  modport slave (
    input  task_valid, task_x, task_size, task_flip,
    input  task_addr, task_line, task_page, task_pal,
    output task_ready
  );
endinterface

// File: rtl/video_ts_task_sched_fifo.sv
// Small synchronous task FIFO with flush and a
// registered head entry for the renderer.
module video_ts_task_fifo
  import video_ts_pkg::*;
#(
  parameter int DEPTH_LOG2 = 2
) (
  input  logic     clk,
  input  logic     reset,
  input  logic     flush,
  input  logic     push,
  input  logic     pop,
  input  ts_task_t wdata,
  output ts_task_t rdata,
  output logic     full,
  output logic     empty
);
  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2-1:0] P1 = DEPTH_LOG2'(1);
  localparam logic [DEPTH_LOG2:0]   C1 = (DEPTH_LOG2+1)'(1);

  ts_task_t mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wptr, rptr, rptr_n;
  logic [DEPTH_LOG2:0]   count, left, count_n;
  logic                  push_ok, pop_ok;

  assign full    = count == (DEPTH_LOG2+1)'(DEPTH);
  assign empty   = count == '0;
  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;

  // Next read pointer and occupancy after this cycle.
  always_comb begin
    rptr_n = rptr;
    left   = count;
    if (pop_ok) begin
      rptr_n = rptr + P1;
      left   = count - C1;
    end
    count_n = push_ok ? left + C1 : left;
  end

  // Pointers, count and the registered head entry.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
      rdata <= '0;
    end else if (flush) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
      rdata <= '0;
    end else begin
      if (push_ok) wptr <= wptr + P1;
      rptr  <= rptr_n;
      count <= count_n;
      if (left == '0) begin
        if (push_ok) rdata <= wdata;
      end else begin
        rdata <= mem[rptr_n];
      end
    end
  end

  // Storage array; written only on accepted pushes.
  always_ff @(posedge clk) begin
    if (push_ok && !flush) mem[wptr] <= wdata;
  end
endmodule

// File: rtl/video_ts_task_sched.sv
// TS-line task scheduler: queues render tasks,
// issues them under a per-line DRAM word budget.
module video_ts_task_sched
  import video_ts_pkg::*;
#(
  parameter int DEPTH_LOG2 = 2,
  parameter int BUDGET_W   = 10
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                line_start,
  input  logic [BUDGET_W-1:0] budget,
  video_ts_task_sched_if.slave tq,
  input  logic                list_end,
  output logic                tsr_reset,
  output logic                tsr_go,
  output logic [8:0]          tsr_x_coord,
  output logic [2:0]          tsr_x_size,
  output logic                tsr_flip,
  output logic [5:0]          tsr_addr,
  output logic [8:0]          tsr_line,
  output logic [7:0]          tsr_page,
  output logic [3:0]          tsr_pal,
  input  logic                tsr_mem_rdy,
  output logic                line_done,
  output logic                ovf
);
  ts_state_e           state, state_n;
  ts_task_t            head, wtask;
  logic [BUDGET_W-1:0] remaining, cost;
  logic                empty, full, fits;
  logic                rdy, stop_hit, push, flush;

  assign cost  = BUDGET_W'(ts_cost(head.size));
  assign fits  = cost <= remaining;
  assign push  = tq.task_valid & rdy;
  assign flush = line_start | stop_hit;

  assign tq.task_ready = rdy;
  assign tsr_reset     = line_start | reset;

  assign wtask = '{x: tq.task_x, size: tq.task_size,
                   flip: tq.task_flip, addr: tq.task_addr,
                   line: tq.task_line, page: tq.task_page,
                   pal: tq.task_pal};

  assign tsr_x_coord = head.x;
  assign tsr_x_size  = head.size;
  assign tsr_flip    = head.flip;
  assign tsr_addr    = head.addr;
  assign tsr_line    = head.line;
  assign tsr_page    = head.page;
  assign tsr_pal     = head.pal;

  video_ts_task_fifo #(.DEPTH_LOG2(DEPTH_LOG2)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .flush (flush),
    .push  (push),
    .pop   (tsr_go),
    .wdata (wtask),
    .rdata (head),
    .full  (full),
    .empty (empty)
  );

  // Line sequencing state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_n;
  end

  // Next state: line_start restarts from anywhere.
  always_comb begin
    state_n = state;
    if (line_start) begin
      state_n = ST_RUN;
    end else begin
      unique case (state)
        ST_RUN: begin
          if (!empty && !fits)
            state_n = ST_STOP;
          else if (list_end && empty && tsr_mem_rdy)
            state_n = ST_DONE;
        end
        ST_STOP: begin
          if (empty && tsr_mem_rdy) state_n = ST_DONE;
        end
        default: ;
      endcase
    end
  end

  // Handshake, issue strobe and budget-stop detect.
  always_comb begin
    rdy      = 1'b0;
    tsr_go   = 1'b0;
    stop_hit = 1'b0;
    if (state == ST_RUN && !line_start) begin
      rdy      = ~full;
      tsr_go   = ~empty & tsr_mem_rdy & fits;
      stop_hit = ~empty & ~fits;
    end
  end

  // Budget counter and line status flags.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      remaining <= '0;
      ovf       <= 1'b0;
      line_done <= 1'b0;
    end else begin
      line_done <= state_n == ST_DONE;
      if (line_start) begin
        remaining <= budget;
        ovf       <= 1'b0;
      end else begin
        if (tsr_go)   remaining <= remaining - cost;
        if (stop_hit) ovf <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_video_ts_task_sched.sv
// Bench for video_ts_task_sched: queue-based line
// model checked every cycle plus directed cases.
module tb_video_ts_task_sched;
  logic       clk = 0;
  logic       reset = 0;
  logic       line_start = 0;
  logic       list_end = 0;
  logic [9:0] budget = '0;
  logic       tsr_mem_rdy;
  logic       tsr_reset, tsr_go, tsr_flip;
  logic       line_done, ovf;
  logic [8:0] tsr_x_coord, tsr_line;
  logic [2:0] tsr_x_size;
  logic [5:0] tsr_addr;
  logic [7:0] tsr_page;
  logic [3:0] tsr_pal;

  video_ts_task_sched_if tif();

  video_ts_task_sched dut (
    .clk         (clk),
    .reset       (reset),
    .line_start  (line_start),
    .budget      (budget),
    .tq          (tif),
    .list_end    (list_end),
    .tsr_reset   (tsr_reset),
    .tsr_go      (tsr_go),
    .tsr_x_coord (tsr_x_coord),
    .tsr_x_size  (tsr_x_size),
    .tsr_flip    (tsr_flip),
    .tsr_addr    (tsr_addr),
    .tsr_line    (tsr_line),
    .tsr_page    (tsr_page),
    .tsr_pal     (tsr_pal),
    .tsr_mem_rdy (tsr_mem_rdy),
    .line_done   (line_done),
    .ovf         (ovf)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(string nm, logic [63:0] act,
                     logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h t=%0t",
               nm, act, exp, $time);
    end
  endtask

  // Renderer: busy for rdr_lat clks after each go.
  bit rdr_mode  = 0;
  bit mem_force = 0;
  int rdr_lat   = 8;
  int rdr_busy  = 0;
  assign tsr_mem_rdy = rdr_mode ? (rdr_busy == 0)
                                : mem_force;
  always @(posedge clk) begin
    if (tsr_go) rdr_busy <= rdr_lat;
    else if (rdr_busy > 0) rdr_busy <= rdr_busy - 1;
  end

  // Model: task layout {x,size,flip,addr,line,page,pal}.
  typedef enum {M_IDLE, M_RUN, M_STOP, M_DONE} mst_e;
  mst_e        mst = M_IDLE;
  int          mrem = 0;
  bit          movf = 0;
  logic [39:0] mq[$];
  int          go_cnt = 0;
  logic [39:0] go_log[$];

  function automatic int costof(logic [39:0] t);
    return 2 * (int'(t[30:28]) + 1);
  endfunction

  always @(negedge clk) begin
    logic [39:0] cur, hd;
    int n;
    bit er, eg, hfit;
    cur = {tif.task_x, tif.task_size, tif.task_flip,
           tif.task_addr, tif.task_line, tif.task_page,
           tif.task_pal};
    hd = {tsr_x_coord, tsr_x_size, tsr_flip, tsr_addr,
          tsr_line, tsr_page, tsr_pal};
    n = mq.size();
    chk("tsr_reset", tsr_reset, line_start | reset);
    if (reset) begin
      mq.delete();
      mst = M_IDLE; mrem = 0; movf = 0;
      chk("rst_go", tsr_go, 0);
      chk("rst_ready", tif.task_ready, 0);
      chk("rst_done", line_done, 0);
      chk("rst_ovf", ovf, 0);
      chk("rst_head", hd, 0);
    end else begin
      hfit = n > 0 && costof(mq[0]) <= mrem;
      er = mst == M_RUN && !line_start && n < 4;
      eg = mst == M_RUN && !line_start && n > 0 &&
           tsr_mem_rdy && hfit;
      chk("ready", tif.task_ready, er);
      chk("go", tsr_go, eg);
      chk("line_done", line_done, mst == M_DONE);
      chk("ovf", ovf, movf);
      if (n > 0) chk("head", hd, mq[0]);
      if (tsr_go && rdr_mode) chk("go_busy", rdr_busy, 0);
      if (tsr_go) begin
        go_cnt++;
        go_log.push_back(hd);
      end
      if (line_start) begin
        mq.delete();
        mrem = int'(budget); movf = 0; mst = M_RUN;
      end else if (mst == M_RUN) begin
        if (n > 0 && !hfit) begin
          mst = M_STOP; movf = 1; mq.delete();
        end else begin
          if (list_end && n == 0 && tsr_mem_rdy) mst = M_DONE;
          if (eg) begin
            mrem -= costof(mq[0]);
            void'(mq.pop_front());
          end
          if (tif.task_valid && er) mq.push_back(cur);
        end
      end else if (mst == M_STOP) begin
        if (n == 0 && tsr_mem_rdy) mst = M_DONE;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_task(logic [39:0] t, bit v);
    {tif.task_x, tif.task_size, tif.task_flip,
     tif.task_addr, tif.task_line, tif.task_page,
     tif.task_pal} = t;
    tif.task_valid = v;
  endtask

  function automatic logic [39:0] mk(int x, int sz, int pg);
    logic [39:0] t;
    t = '0;
    t[39:31] = 9'(x);
    t[30:28] = 3'(sz);
    t[11:4]  = 8'(pg);
    t[27]    = 1'(x);
    return t;
  endfunction

  function automatic logic [39:0] rtask();
    logic [39:0] t;
    t = 40'({$urandom, $urandom});
    t[30:28] = 3'($urandom_range(0, 7));
    return t;
  endfunction

  task automatic start_line(int b, bit v);
    line_start = 1;
    budget = 10'(b);
    list_end = 0;
    drive_task(rtask(), v);
    @(negedge clk);
    chk("ls_tsr_reset", tsr_reset, 1);
    chk("ls_no_go", tsr_go, 0);
    step();
    line_start = 0;
    tif.task_valid = 0;
  endtask

  task automatic push(logic [39:0] t, int lim, output bit ok);
    ok = 0;
    drive_task(t, 1);
    for (int i = 0; i < lim && !ok; i++) begin
      @(negedge clk);
      if (tif.task_ready) ok = 1;
      step();
    end
    tif.task_valid = 0;
  endtask

  task automatic wait_done(string nm, int lim);
    int i;
    i = 0;
    while (i < lim) begin
      @(negedge clk);
      if (line_done) break;
      i++;
    end
    chk(nm, line_done, 1);
    step();
  endtask

  initial begin
    bit ok;
    int g0, nt, pushed, cyc;
    bit abort;
    drive_task('0, 0);
    #1 reset = 1;
    repeat (3) @(posedge clk);
    #1 reset = 0;
    @(negedge clk);
    chk("idle_ready", tif.task_ready, 0);
    chk("idle_done", line_done, 0);
    step();

    // 1: three size-0 tasks against budget 64
    rdr_mode = 1; rdr_lat = 8;
    start_line(64, 0);
    g0 = go_cnt;
    for (int i = 0; i < 3; i++) begin
      push(mk(i + 1, 0, i), 20, ok);
      chk("t1_push", ok, 1);
    end
    list_end = 1;
    wait_done("t1_done", 200);
    chk("t1_gos", go_cnt - g0, 3);
    chk("t1_rem", dut.remaining, 58);

    // 2: fill FIFO with renderer stalled
    rdr_mode = 0; mem_force = 0;
    start_line(1000, 0);
    g0 = go_cnt;
    go_log.delete();
    for (int i = 0; i < 4; i++) begin
      push(mk((i + 1) * 10, i % 2, i + 5), 20, ok);
      chk("t2_push", ok, 1);
    end
    drive_task(mk(50, 2, 9), 1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t2_full_ready", tif.task_ready, 0);
      step();
    end
    rdr_lat = 2; rdr_mode = 1;
    push(mk(50, 2, 9), 50, ok);
    chk("t2_push5", ok, 1);
    list_end = 1;
    wait_done("t2_done", 200);
    chk("t2_gos", go_cnt - g0, 5);
    if (go_log.size() >= 5)
      for (int i = 0; i < 5; i++)
        chk("t2_order", go_log[i][39:31], (i + 1) * 10);

    // 3: budget 20, costs 16, 4, 2
    rdr_lat = 3;
    start_line(20, 0);
    g0 = go_cnt;
    push(mk(1, 7, 1), 20, ok); chk("t3_push", ok, 1);
    push(mk(2, 1, 2), 20, ok); chk("t3_push", ok, 1);
    push(mk(3, 0, 3), 20, ok); chk("t3_push", ok, 1);
    wait_done("t3_done", 100);
    chk("t3_gos", go_cnt - g0, 2);
    chk("t3_rem", dut.remaining, 0);
    chk("t3_ovf", ovf, 1);

    // 5: line_start with push clears flags and drops task
    start_line(100, 1);
    @(negedge clk);
    chk("t5_ovf_clr", ovf, 0);
    chk("t5_done_clr", line_done, 0);
    step();
    g0 = go_cnt;
    repeat (5) step();
    chk("t5_lost_a", go_cnt - g0, 0);
    rdr_mode = 0; mem_force = 0;
    push(mk(7, 0, 1), 10, ok); chk("t5_push", ok, 1);
    push(mk(8, 0, 2), 10, ok); chk("t5_push", ok, 1);
    start_line(100, 1);
    rdr_mode = 1;
    g0 = go_cnt;
    repeat (6) step();
    chk("t5_lost_b", go_cnt - g0, 0);

    // 6: async reset mid-cycle during RUN
    rdr_mode = 0; mem_force = 0;
    start_line(200, 0);
    push(mk(11, 1, 4), 10, ok); chk("t6_push", ok, 1);
    push(mk(12, 1, 5), 10, ok); chk("t6_push", ok, 1);
    @(negedge clk);
    mem_force = 1;
    #1 chk("t6_go_pre", tsr_go, 1);
    reset = 1;
    #1;
    chk("t6_go", tsr_go, 0);
    chk("t6_ready", tif.task_ready, 0);
    chk("t6_tsr_reset", tsr_reset, 1);
    chk("t6_head", tsr_x_coord, 0);
    chk("t6_ovf", ovf, 0);
    repeat (2) @(posedge clk);
    #1 reset = 0;
    mem_force = 0;
    drive_task(mk(13, 0, 0), 1);
    repeat (3) begin
      @(negedge clk);
      chk("t6_idle_ready", tif.task_ready, 0);
      step();
    end
    tif.task_valid = 0;
    start_line(50, 0);
    @(negedge clk);
    chk("t6_run_ready", tif.task_ready, 1);
    step();

    // 4 + random lines
    for (int l = 0; l < 40; l++) begin
      rdr_mode = ($urandom_range(0, 3) != 0);
      rdr_lat = $urandom_range(1, 6);
      start_line($urandom_range(0, 120),
                 1'($urandom_range(0, 1)));
      nt = $urandom_range(0, 7);
      abort = ($urandom_range(0, 7) == 0);
      pushed = 0; cyc = 0;
      while (pushed < nt && cyc < 60) begin
        drive_task(rtask(), $urandom_range(0, 3) != 0);
        if (!rdr_mode) mem_force = 1'($urandom_range(0, 1));
        @(negedge clk);
        if (tif.task_valid && tif.task_ready) pushed++;
        step();
        cyc++;
      end
      tif.task_valid = 0;
      rdr_mode = 1;
      if (!abort) begin
        list_end = 1;
        wait_done("rnd_done", 400);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
